// File: rtl/eeg_pkg.sv
// eeg_pkg: shared sample width, sample type and writer-state encoding for the EEG preprocessing chain
package eeg_pkg;
    localparam int EEG_DATA_W = 32;
    typedef enum logic {FILL, STALL} wbuf_state_e;
    typedef logic signed [EEG_DATA_W-1:0] sample_t;
endpackage

// File: rtl/window_ram.sv
// window_ram: simple dual-port RAM with a registered read port; infers block RAM
// ports: clk, rst_n (sync, active-low, clears only the read register),
//        i_we/i_waddr/i_wdata write port, i_raddr -> o_rdata one cycle later
module window_ram
    import eeg_pkg::*;
#(
    parameter int DATA_W = EEG_DATA_W,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**AW];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= !rst_n ? '0 : r_mem[i_raddr];
    end
endmodule

// File: rtl/eeg_window_buffer.sv
// eeg_window_buffer: ping-pong window buffer capturing filtered samples into windows with drop-and-count back-pressure
// ports: clk, rst_n (sync, active-low); enable/sample_in sample stream in;
//        rd_addr/rd_data random-access read of the ready window (1-cycle latency);
//        win_ready/win_done window handshake; overrun (sticky) and drop_count (saturating)
module eeg_window_buffer
    import eeg_pkg::*;
#(
    parameter int DATA_W  = EEG_DATA_W,
    parameter int WIN_LEN = 256,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [DATA_W-1:0]          sample_in,
    input  logic [$clog2(WIN_LEN)-1:0] rd_addr,
    input  logic                       win_done,
    output logic                       win_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       overrun,
    output logic [CNT_W-1:0]           drop_count
);
    localparam int AW = $clog2(WIN_LEN);
    wbuf_state_e      r_state;
    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic             r_win_ready;
    logic             r_overrun;
    logic [AW-1:0]    r_wr_idx;
    logic [CNT_W-1:0] r_drop_count;
    logic [1:0]       w_full_nxt;
    logic             w_release;
    logic             w_wr;
    logic             w_last;
    logic             w_drop;
    logic             w_other_free;
    assign w_release = win_done & r_full[r_rd_bank];
    assign w_wr      = rst_n & enable & (r_state == FILL);
    assign w_drop    = enable & (r_state == STALL);
    assign w_last    = w_wr & (&r_wr_idx);
    // A release and a window completion in the same cycle touch different banks, so both apply
    assign w_full_nxt   = (r_full & ~({1'b0, w_release} << r_rd_bank)) | ({1'b0, w_last} << r_wr_bank);
    // Judged on the post-release view so a same-cycle win_done avoids a needless stall
    assign w_other_free = ~w_full_nxt[~r_wr_bank];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= FILL;
            r_full       <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_win_ready  <= 1'b0;
            r_overrun    <= 1'b0;
            r_wr_idx     <= '0;
            r_drop_count <= '0;
        end else begin
            r_full      <= w_full_nxt;
            r_rd_bank   <= r_rd_bank ^ w_release;
            r_win_ready <= w_full_nxt[r_rd_bank ^ w_release];
            if (w_wr) r_wr_idx <= r_wr_idx + 1'b1;
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (!(&r_drop_count)) r_drop_count <= r_drop_count + 1'b1;
            end
            if (w_last || r_state == STALL) begin
                if (w_other_free) begin
                    r_wr_bank <= ~r_wr_bank;
                    r_state   <= FILL;
                end else begin
                    r_state   <= STALL;
                end
            end
        end
    end
    window_ram #(.DATA_W(DATA_W), .AW(AW + 1)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_wr),
        .i_waddr ({r_wr_bank, r_wr_idx}),
        .i_wdata (sample_in),
        .i_raddr ({r_rd_bank, rd_addr}),
        .o_rdata (rd_data)
    );
    assign win_ready  = r_win_ready;
    assign overrun    = r_overrun;
    assign drop_count = r_drop_count;
endmodule

// File: tb/tb_eeg_window_buffer.sv
// tb_eeg_window_buffer: scoreboard bench for the ping-pong window buffer with WIN_LEN=8
module tb_eeg_window_buffer;
    import eeg_pkg::*;
    localparam int WIN = 8;
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    sample_t         sample_in = '0;
    logic [2:0]      rd_addr = '0;
    logic            win_done = 1'b0;
    logic            win_ready;
    logic [31:0]     rd_data;
    logic            overrun;
    logic [15:0]     drop_count;
    int              n_cmp = 0;
    int              n_err = 0;
    int              exp_q[$];
    eeg_window_buffer #(.DATA_W(32), .WIN_LEN(WIN), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sample_in  (sample_in),
        .rd_addr    (rd_addr),
        .win_done   (win_done),
        .win_ready  (win_ready),
        .rd_data    (rd_data),
        .overrun    (overrun),
        .drop_count (drop_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input int v, input bit keep);
        enable = 1'b1;
        sample_in = v;
        if (keep) exp_q.push_back(v);
        tick();
        enable = 1'b0;
    endtask
    task automatic read_window(input string tag);
        int e;
        for (int i = 0; i < WIN; i++) begin
            rd_addr = 3'(i);
            tick();
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
            chk(tag, rd_data, e);
        end
    endtask
    task automatic done();
        win_done = 1'b1;
        tick();
        win_done = 1'b0;
    endtask
    initial begin
        #1;
        enable = 1'b1;
        sample_in = 55;
        tick();
        tick();
        chk("rst_win_ready", win_ready, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        enable = 1'b0;
        tick();
        for (int i = -3; i <= 3; i++) send(i, 1);
        chk("single_not_ready_early", win_ready, 0);
        send(4, 1);
        chk("single_ready", win_ready, 1);
        read_window("single_rd");
        done();
        chk("single_done_drop", win_ready, 0);
        for (int i = 100; i < 116; i++) send(i, 1);
        chk("pp_ready", win_ready, 1);
        chk("pp_no_drop", drop_count, 0);
        read_window("pp_rd0");
        done();
        chk("pp_ready_after_done", win_ready, 1);
        read_window("pp_rd1");
        done();
        chk("pp_empty", win_ready, 0);
        for (int i = 0; i < 20; i++) send(200 + i, i < 16);
        chk("ovr_flag", overrun, 1);
        chk("ovr_drop", drop_count, 4);
        read_window("ovr_rd0");
        done();
        for (int i = 300; i < 308; i++) send(i, 1);
        chk("ovr_drop_after", drop_count, 4);
        read_window("ovr_rd1");
        done();
        read_window("ovr_rd2");
        done();
        chk("ovr_empty", win_ready, 0);
        for (int i = 400; i < 415; i++) send(i, 1);
        read_window("sim_rd0");
        chk("sim_ready_before", win_ready, 1);
        win_done = 1'b1;
        send(415, 1);
        win_done = 1'b0;
        chk("sim_ready_cont", win_ready, 1);
        chk("sim_no_drop", drop_count, 4);
        for (int i = 500; i < 508; i++) send(i, 1);
        chk("sim_no_drop2", drop_count, 4);
        read_window("sim_rd1");
        done();
        read_window("sim_rd2");
        done();
        chk("sim_empty", win_ready, 0);
        for (int i = 600; i < 605; i++) send(i, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_drop", drop_count, 0);
        for (int i = 7; i < 15; i++) send(i, 1);
        chk("mid_rst_ready", win_ready, 1);
        read_window("mid_rst_rd");
        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/eeg_window_buffer.md
# eeg_window_buffer

Ping-pong window buffer that sits on the output side of the biquad highpass filter: it captures the filtered EEG sample stream (one sample per `enable` strobe) into fixed-length, non-overlapping windows and hands each completed window to the downstream feature extractor through a ready/done handshake with random-access reads. It is the consumer end of the filter's `enable`/`filter_out` stream. It is the first block that applies back-pressure policy, which is drop-and-count, to the preprocessor chain.

## Interface
- `DATA_W`, 32: signed sample width; must match the filter output.
- `WIN_LEN`, 256: samples per window; power of two, 4 or greater.
- `CNT_W`, 16: width of the drop counter.
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: reset, synchronous and active-low; one clock, active low.
- `enable` in 1: sample strobe; `sample_in` is valid in any cycle where it is high.
- `sample_in` in `DATA_W`: filtered sample (signed).
- `rd_addr` in `$clog2(WIN_LEN)`: sample index within the ready window.
- `win_done` in 1: one-cycle pulse from the consumer that releases the ready window.
- `win_ready` out 1: a complete window is available for reading.
- `rd_data` out `DATA_W`: sample `rd_addr` of the ready window.
- `overrun` out 1: sticky flag; a sample has been dropped since reset.
- `drop_count` out `CNT_W`: number of dropped samples; saturates at all-ones.

## Operation
- Storage is two banks, each holding `WIN_LEN` samples. Each bank has a `full` bit.
- State: write bank `wr_bank`, write index `wr_idx`, read bank `rd_bank`.
- Writer FSM:
  - `FILL`: each `enable` writes `sample_in` to `wr_bank[wr_idx]` and increments `wr_idx`.
  - When the write lands at index `WIN_LEN-1`: set `full[wr_bank]` and reset `wr_idx` to 0.
  - After that last write, if the other bank is not full, toggle `wr_bank` and stay in `FILL`. Otherwise go to `STALL`.
  - `STALL`: each `enable` drops the sample, sets `overrun` and increments `drop_count` (saturating). Leave `STALL` when the other bank's `full` bit clears. `wr_bank` then toggles and the state returns to `FILL`.
- Reader side:
  - `win_ready = full[rd_bank]`.
  - `win_done` while `win_ready` is high clears `full[rd_bank]` and toggles `rd_bank`.
  - `win_done` while `win_ready` is low is ignored.
- Windows are delivered strictly in capture order and never overlap. No sample within a window is ever lost or reordered.
- Samples are stored unmodified; there is no arithmetic on data.
- Reset clears all `full` bits, `wr_bank`, `rd_bank`, `wr_idx`, `overrun`, `drop_count` and `rd_data` to 0. The writer starts in `FILL`.
- RAM contents are not cleared by reset. Reset mid-window discards the partial window.

## Timing
- If the write of index `WIN_LEN-1` happens in cycle N, `win_ready` is high in cycle N+1.
- `rd_data` is registered: `rd_addr` presented in cycle N gives data in cycle N+1. This holds for any `rd_addr` while `win_ready` is high.
- `win_done` in cycle N drops `win_ready` in cycle N+1. If the other bank is already full, `win_ready` stays high in N+1 and now points to the other bank.
- `win_done` in the same cycle as the window-completing write of the other bank: both take effect. In N+1, `win_ready` is high, `rd_bank` points to the newly completed bank, and the writer moves to the freed bank. It does not stall.
- In `STALL`, a release by `win_done` in cycle N makes the writer accept samples from cycle N+1. An `enable` in cycle N itself is dropped and counted.
- `enable` is accepted back-to-back every cycle. There is no throughput limit other than bank availability.
- All outputs are driven from registers. There is no combinational path from any input to any output.

## Structure
- Shared package `eeg_pkg` holds:
  - `EEG_DATA_W` (32) as the shared sample width;
  - the writer-state enum `wbuf_state_e` (`FILL`, `STALL`);
  - a `sample_t` typedef, `logic signed [EEG_DATA_W-1:0]`.
- One sub-module, `window_ram`: a simple dual-port RAM with depth `2*WIN_LEN`, registered read port, and address formed as `{bank, idx}`. It is written so it infers block RAM.
- Top level holds the writer FSM, the bank bookkeeping and the counters.

## Test plan
Run with `WIN_LEN`=8 and `DATA_W`=32.
- Reset behaviour: `rst_n` low for 2 cycles with `enable` high → `win_ready`=0, `overrun`=0, `drop_count`=0, `rd_data`=0. No sample is captured.
- Single window: 8 consecutive samples −3..4 → `win_ready` rises the cycle after the 8th. Reading `rd_addr` 0..7 returns −3..4, each one cycle after its address. `win_done` drops `win_ready` the next cycle.
- Ping-pong: 16 samples 100..115 with no `win_done` → window 0 reads 100..107. After `win_done`, `win_ready` stays high and reads 108..115.
- Overrun: 20 samples with no `win_done` → `overrun`=1 and `drop_count`=4. Then `win_done` followed by 8 samples → the third window holds exactly those 8 samples.
- Simultaneous events: the 8th sample of bank 1 arrives in the same cycle as `win_done` for bank 0 → no drop, `win_ready` is continuous, and the next sample lands in bank 0 at index 0.
- Mid-window reset: 5 samples, then `rst_n` low for 1 cycle, then 8 samples 7..14 → the first window reads 7..14.
